// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter and fetch sequencer for picoMIPS.
// Advances the PC on decoder requests. On a LOAD it holds the PC until the
// GO button gives a fresh, synchronised rising edge. It then strobes load_en
// for one cycle and advances.
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-high reset
//   PCincr   decoder request to advance the PC
//   is_load  current instruction is LOAD
//   go_sw    raw asynchronous GO push-button, active-high
//   PCout    current program address (registered)
//   stall    suppress register-file writes (combinational, from registered state)
//   load_en  one-cycle strobe to capture switch data (combinational, from registered state)
//   halted   program finished, PC frozen (registered)
//
// Optional feature macro: PC_WRAP_EN. When it is defined, an advance at
// PROG_LAST wraps the PC to 0, HALT is never entered, and halted is held at 0.

module pc_sequencer #(
    parameter int unsigned PSIZE       = 6,
    parameter int unsigned PROG_LAST   = 63,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PCincr,
    input  logic             is_load,
    input  logic             go_sw,
    output logic [PSIZE-1:0] PCout,
    output logic             stall,
    output logic             load_en,
    output logic             halted
);

    localparam logic [1:0] S_RUN          = 2'd0;
    localparam logic [1:0] S_WAIT_PRESS   = 2'd1;
    localparam logic [1:0] S_WAIT_RELEASE = 2'd2;
    localparam logic [1:0] S_HALT         = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [PSIZE-1:0]       pc_q, pc_d;
    logic                   halted_q, halted_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   go_prev_q;
    logic                   go_s;
    logic                   go_rise;
    logic                   at_last;

    // GO synchroniser chain plus edge-detect flop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q    <= '0;
            go_prev_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], go_sw};
            go_prev_q <= go_s;
        end
    end

    assign go_s    = sync_q[SYNC_STAGES-1];
    // Built only from flops, so load_en cannot glitch within a cycle
    assign go_rise = go_s & ~go_prev_q;
    assign at_last = (pc_q == PSIZE'(PROG_LAST));

    // State, PC and halted registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_RUN;
            pc_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            halted_q <= halted_d;
        end
    end

    // Next-state, next-PC and combinational stall/load_en decode
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        halted_d = halted_q;
        stall    = 1'b0;
        load_en  = 1'b0;

        case (state_q)
            S_RUN: begin
                // An advance request has priority over is_load
                if (PCincr) begin
                    if (at_last) begin
`ifdef PC_WRAP_EN
                        pc_d = '0;
`else
                        state_d  = S_HALT;
                        halted_d = 1'b1;
`endif
                    end else begin
                        pc_d = pc_q + PSIZE'(1);
                    end
                end else if (is_load) begin
                    state_d = S_WAIT_PRESS;
                end
            end

            S_WAIT_PRESS: begin
                stall = 1'b1;
                // Only a fresh rising edge counts, so a held button never double-loads
                if (go_rise) begin
                    stall   = 1'b0;
                    load_en = 1'b1;
                    if (at_last) begin
`ifdef PC_WRAP_EN
                        pc_d    = '0;
                        state_d = S_RUN;
`else
                        state_d  = S_HALT;
                        halted_d = 1'b1;
`endif
                    end else begin
                        pc_d    = pc_q + PSIZE'(1);
                        state_d = S_WAIT_RELEASE;
                    end
                end
            end

            S_WAIT_RELEASE: begin
                stall = 1'b1;
                if (!go_s) begin
                    state_d = S_RUN;
                end
            end

            S_HALT: begin
                stall = 1'b1;
            end

            default: begin
                state_d = S_RUN;
            end
        endcase

`ifdef PC_WRAP_EN
        halted_d = 1'b0;
`endif
    end

    assign PCout  = pc_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer.
// The DUT is built with PROG_LAST=7 so that the end of program is reachable.
// Expected values follow PC_WRAP_EN if the bench is compiled with that macro.

module tb_pc_sequencer;

    localparam int unsigned PSIZE       = 6;
    localparam int unsigned PROG_LAST   = 7;
    localparam int unsigned SYNC_STAGES = 2;

    logic             clk;
    logic             reset;
    logic             PCincr;
    logic             is_load;
    logic             go_sw;
    logic [PSIZE-1:0] PCout;
    logic             stall;
    logic             load_en;
    logic             halted;

    int n_checks;
    int n_pass;
    int pulses;

    pc_sequencer #(
        .PSIZE      (PSIZE),
        .PROG_LAST  (PROG_LAST),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .PCincr (PCincr),
        .is_load(is_load),
        .go_sw  (go_sw),
        .PCout  (PCout),
        .stall  (stall),
        .load_en(load_en),
        .halted (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        PCincr   = 1'b0;
        is_load  = 1'b0;
        go_sw    = 1'b0;

        // Reset state
        tick(2);
        check("rst_pc", 32'(PCout), 0);
        check("rst_stall", 32'(stall), 0);
        check("rst_load_en", 32'(load_en), 0);
        check("rst_halted", 32'(halted), 0);
        reset = 1'b0;

        // Sequential advance 0 -> 4
        PCincr = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            check("adv_pc", 32'(PCout), 32'(i));
            check("adv_stall", 32'(stall), 0);
        end

        // Asynchronous reset between edges at PC=5
        tick(1);
        check("pre_async_pc", 32'(PCout), 5);
        PCincr = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        check("async_pc", 32'(PCout), 0);
        check("async_halted", 32'(halted), 0);
        check("async_stall", 32'(stall), 0);
        tick(1);
        reset = 1'b0;

        // LOAD stall at PC=3
        PCincr = 1'b1;
        tick(3);
        check("to3_pc", 32'(PCout), 3);
        PCincr  = 1'b0;
        is_load = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("ld_wait_pc", 32'(PCout), 3);
            check("ld_wait_stall", 32'(stall), 1);
            check("ld_wait_load_en", 32'(load_en), 0);
        end
        go_sw = 1'b1;
        tick(SYNC_STAGES - 1);
        check("ld_early_load_en", 32'(load_en), 0);
        tick(1);
        check("ld_strobe", 32'(load_en), 1);
        check("ld_strobe_stall", 32'(stall), 0);
        check("ld_strobe_pc", 32'(PCout), 3);
        is_load = 1'b0;
        tick(1);
        check("ld_after_load_en", 32'(load_en), 0);
        check("ld_after_pc", 32'(PCout), 4);
        check("ld_release_wait", 32'(stall), 1);
        go_sw = 1'b0;
        tick(2);
        check("ld_rel_stall_hold", 32'(stall), 1);
        tick(1);
        check("ld_rel_run", 32'(stall), 0);

        // Held button: entering WAIT_PRESS with GO already high must not load
        go_sw = 1'b1;
        tick(SYNC_STAGES + 2);
        is_load = 1'b1;
        pulses  = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (load_en) pulses++;
        end
        check("held_no_load", 32'(pulses), 0);
        check("held_stall", 32'(stall), 1);
        check("held_pc", 32'(PCout), 4);
        go_sw = 1'b0;
        tick(4);
        check("held_rel_stall", 32'(stall), 1);
        go_sw  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (load_en) begin
                pulses++;
                is_load = 1'b0;
            end
        end
        check("held_single_pulse", 32'(pulses), 1);
        check("held_pc_adv", 32'(PCout), 5);
        go_sw = 1'b0;
        tick(4);
        check("held_back_run", 32'(stall), 0);

        // End of program at PROG_LAST=7
        is_load = 1'b0;
        PCincr  = 1'b1;
        tick(2);
        check("eop_pc7", 32'(PCout), 7);
        check("eop_pre_halted", 32'(halted), 0);
        tick(1);
`ifdef PC_WRAP_EN
        check("eop_wrap_pc", 32'(PCout), 0);
        check("eop_wrap_halted", 32'(halted), 0);
        check("eop_wrap_stall", 32'(stall), 0);
`else
        check("eop_pc", 32'(PCout), 7);
        check("eop_halted", 32'(halted), 1);
        check("eop_stall", 32'(stall), 1);
        tick(3);
        check("eop_frozen_pc", 32'(PCout), 7);
        check("eop_frozen_halted", 32'(halted), 1);
`endif
        PCincr = 1'b0;

        // Reset during WAIT_PRESS in the cycle go_rise is high
        reset = 1'b1;
        tick(1);
        reset  = 1'b0;
        PCincr = 1'b1;
        tick(2);
        check("rwp_pc2", 32'(PCout), 2);
        PCincr  = 1'b0;
        is_load = 1'b1;
        tick(2);
        go_sw = 1'b1;
        tick(SYNC_STAGES);
        check("rwp_strobe_seen", 32'(load_en), 1);
        #2;
        reset = 1'b1;
        #1;
        check("rwp_load_en_cancel", 32'(load_en), 0);
        check("rwp_pc", 32'(PCout), 0);
        check("rwp_stall", 32'(stall), 0);
        tick(1);
        reset   = 1'b0;
        is_load = 1'b0;
        pulses  = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (load_en) pulses++;
        end
        check("rwp_no_late_pulse", 32'(pulses), 0);
        check("rwp_pc_hold", 32'(PCout), 0);
        go_sw = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
